// File: rtl/wb_regfile.sv
// Writeback stage plus 32-entry architectural register file with two
// decode read ports, same-cycle write-through bypass and commit bookkeeping.
module wb_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_isValid,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic              wb_mem_read,
    input  logic              wb_mem_write,
    input  logic              wb_reg_write,
    input  logic [DATA_W-1:0] wb_aluResult,
    input  logic [DATA_W-1:0] wb_memResult,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    output logic [DATA_W-1:0] id_rs1_data,
    output logic [DATA_W-1:0] id_rs2_data,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_we,
    output logic [31:0]       wb_write_count,
    output logic [ADDR_W-1:0] wb_last_rd
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [31:0]       count_q, count_d;
    logic [ADDR_W-1:0] last_rd_q, last_rd_d;
    logic              rd_nonzero;

    // A store wins over reg_write; writes to x0 are dropped before they count.
    assign rd_nonzero = (wb_rd != '0);
    assign wb_data    = wb_mem_read ? wb_memResult : wb_aluResult;
    assign wb_we      = wb_isValid & wb_reg_write & ~wb_mem_write & rd_nonzero;

    always_comb begin
        count_d   = count_q;
        last_rd_d = last_rd_q;
        if (wb_we) begin
            count_d   = count_q + 32'd1;
            last_rd_d = wb_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            count_q   <= '0;
            last_rd_q <= '0;
        end else begin
            if (wb_we) begin
                regs_q[wb_rd] <= wb_data;
            end
            count_q   <= count_d;
            last_rd_q <= last_rd_d;
        end
    end

    always_comb begin
        id_rs1_data = '0;
        if (id_rs1 == '0) begin
            id_rs1_data = '0;
        end else if (wb_we && (id_rs1 == wb_rd)) begin
            id_rs1_data = wb_data;
        end else begin
            id_rs1_data = regs_q[id_rs1];
        end
    end

    always_comb begin
        id_rs2_data = '0;
        if (id_rs2 == '0) begin
            id_rs2_data = '0;
        end else if (wb_we && (id_rs2 == wb_rd)) begin
            id_rs2_data = wb_data;
        end else begin
            id_rs2_data = regs_q[id_rs2];
        end
    end

    assign wb_write_count = count_q;
    assign wb_last_rd     = last_rd_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: hand-computed expectations checked with
// immediate assertions, sampled one time unit after driving or after the edge.
module tb_wb_regfile;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              reset;
    logic              wb_isValid;
    logic [ADDR_W-1:0] wb_rd;
    logic              wb_mem_read;
    logic              wb_mem_write;
    logic              wb_reg_write;
    logic [DATA_W-1:0] wb_aluResult;
    logic [DATA_W-1:0] wb_memResult;
    logic [ADDR_W-1:0] id_rs1;
    logic [ADDR_W-1:0] id_rs2;
    logic [DATA_W-1:0] id_rs1_data;
    logic [DATA_W-1:0] id_rs2_data;
    logic [DATA_W-1:0] wb_data;
    logic              wb_we;
    logic [31:0]       wb_write_count;
    logic [ADDR_W-1:0] wb_last_rd;

    int tests_run;
    int tests_failed;

    wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .wb_isValid     (wb_isValid),
        .wb_rd          (wb_rd),
        .wb_mem_read    (wb_mem_read),
        .wb_mem_write   (wb_mem_write),
        .wb_reg_write   (wb_reg_write),
        .wb_aluResult   (wb_aluResult),
        .wb_memResult   (wb_memResult),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rs1_data    (id_rs1_data),
        .id_rs2_data    (id_rs2_data),
        .wb_data        (wb_data),
        .wb_we          (wb_we),
        .wb_write_count (wb_write_count),
        .wb_last_rd     (wb_last_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wb_isValid   = 1'b0;
        wb_rd        = '0;
        wb_mem_read  = 1'b0;
        wb_mem_write = 1'b0;
        wb_reg_write = 1'b0;
        wb_aluResult = '0;
        wb_memResult = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_alu(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] val);
        wb_isValid   = 1'b1;
        wb_reg_write = 1'b1;
        wb_mem_read  = 1'b0;
        wb_mem_write = 1'b0;
        wb_rd        = rd;
        wb_aluResult = val;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        idle();
        id_rs1 = '0;
        id_rs2 = '0;
        reset  = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Reset state
        check("rst_count", wb_write_count, 32'd0);
        check("rst_last_rd", {27'd0, wb_last_rd}, 32'd0);
        for (int i = 1; i < 32; i++) begin
            id_rs1 = i[ADDR_W-1:0];
            id_rs2 = i[ADDR_W-1:0];
            #1;
            check("rst_rs1", id_rs1_data, 32'd0);
            check("rst_rs2", id_rs2_data, 32'd0);
        end

        // ALU write to x5 with same-cycle bypass
        write_alu(5'd5, 32'h1234_5678);
        id_rs1 = 5'd5;
        id_rs2 = 5'd6;
        #1;
        check("alu_we", {31'd0, wb_we}, 32'd1);
        check("alu_wb_data", wb_data, 32'h1234_5678);
        check("alu_bypass_rs1", id_rs1_data, 32'h1234_5678);
        check("alu_rs2_other", id_rs2_data, 32'd0);
        tick();
        idle();
        #1;
        check("alu_stored_rs1", id_rs1_data, 32'h1234_5678);
        check("alu_count", wb_write_count, 32'd1);
        check("alu_last_rd", {27'd0, wb_last_rd}, 32'd5);

        // Load write to x7 selects memResult
        write_alu(5'd7, 32'h0000_0100);
        wb_mem_read  = 1'b1;
        wb_memResult = 32'hDEAD_BEEF;
        id_rs2 = 5'd7;
        #1;
        check("load_wb_data", wb_data, 32'hDEAD_BEEF);
        check("load_bypass_rs2", id_rs2_data, 32'hDEAD_BEEF);
        tick();
        idle();
        id_rs1 = 5'd7;
        #1;
        check("load_stored_rs1", id_rs1_data, 32'hDEAD_BEEF);
        check("load_count", wb_write_count, 32'd2);
        check("load_last_rd", {27'd0, wb_last_rd}, 32'd7);

        // Store with reg_write set must not write x8
        write_alu(5'd8, 32'h0000_0055);
        wb_mem_write = 1'b1;
        id_rs1 = 5'd8;
        #1;
        check("store_we", {31'd0, wb_we}, 32'd0);
        check("store_no_bypass", id_rs1_data, 32'd0);
        tick();
        idle();
        #1;
        check("store_x8", id_rs1_data, 32'd0);
        check("store_count", wb_write_count, 32'd2);
        check("store_last_rd", {27'd0, wb_last_rd}, 32'd7);

        // Write to x0 is dropped
        write_alu(5'd0, 32'hFFFF_FFFF);
        id_rs1 = 5'd0;
        id_rs2 = 5'd0;
        #1;
        check("x0_we", {31'd0, wb_we}, 32'd0);
        check("x0_rs1", id_rs1_data, 32'd0);
        check("x0_rs2", id_rs2_data, 32'd0);
        tick();
        idle();
        #1;
        check("x0_count", wb_write_count, 32'd2);
        check("x0_last_rd", {27'd0, wb_last_rd}, 32'd7);

        // Stale MEM/WB contents with isValid low for 3 cycles
        wb_reg_write = 1'b1;
        wb_rd        = 5'd9;
        wb_aluResult = 32'h0000_0099;
        id_rs1 = 5'd9;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stale_we", {31'd0, wb_we}, 32'd0);
            check("stale_rs1", id_rs1_data, 32'd0);
            tick();
            check("stale_count", wb_write_count, 32'd2);
        end
        idle();

        // Both ports read the index being written
        write_alu(5'd5, 32'hCAFE_F00D);
        id_rs1 = 5'd5;
        id_rs2 = 5'd5;
        #1;
        check("dual_bypass_rs1", id_rs1_data, 32'hCAFE_F00D);
        check("dual_bypass_rs2", id_rs2_data, 32'hCAFE_F00D);
        tick();
        idle();
        #1;
        check("dual_stored_rs1", id_rs1_data, 32'hCAFE_F00D);
        check("dual_count", wb_write_count, 32'd3);

        // Reset coinciding with a write: reset wins
        write_alu(5'd3, 32'hAAAA_AAAA);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        id_rs1 = 5'd3;
        id_rs2 = 5'd5;
        #1;
        check("rstw_x3", id_rs1_data, 32'd0);
        check("rstw_x5", id_rs2_data, 32'd0);
        check("rstw_count", wb_write_count, 32'd0);
        check("rstw_last_rd", {27'd0, wb_last_rd}, 32'd0);

        // Counter wrap from a preloaded value
        force dut.count_q = 32'hFFFF_FFFE;
        #1;
        release dut.count_q;
        #1;
        check("wrap_preload", wb_write_count, 32'hFFFF_FFFE);
        write_alu(5'd10, 32'h0000_0001);
        tick();
        check("wrap_max", wb_write_count, 32'hFFFF_FFFF);
        write_alu(5'd11, 32'h0000_0002);
        tick();
        idle();
        id_rs1 = 5'd10;
        id_rs2 = 5'd11;
        #1;
        check("wrap_zero", wb_write_count, 32'd0);
        check("wrap_last_rd", {27'd0, wb_last_rd}, 32'd11);
        check("wrap_x10", id_rs1_data, 32'd1);
        check("wrap_x11", id_rs2_data, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
